// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Source end of the VGA bus. Generates pixel counters, sync and
//               blanking fields for every downstream drawing stage, plus a
//               frame-start pulse and a completed-frame counter for game logic.
//               Every output comes straight from a flop, and all bus fields in
//               a cycle describe the same (hcount, vcount) pixel.
//
// Ports       : pclk        in   pixel clock (40 MHz for the default timing)
//               rst_n       in   asynchronous active-low reset
//               en          in   count enable; low freezes the generator
//               vga_out     out  VGA bus, MSB first:
//                                {hcount[10:0], vcount[10:0], hsync, vsync,
//                                 hblnk, vblnk, rgb[11:0]}
//               frame_start out  one-cycle pulse when the bus shows (0,0)
//                                after a frame wrap
//               frame_cnt   out  completed-frame counter (wraps at 16 bits)
//
// Options     : VGA_TIMING_PATTERN_EN - when defined, rgb carries eight
//               vertical colour bars across the active area; otherwise rgb is
//               constant zero and no bar logic exists.
//
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic                      pclk,
  input  logic                      rst_n,
  input  logic                      en,
  output logic [`VGA_BUS_SIZE-1:0]  vga_out,
  output logic                      frame_start,
  output logic [15:0]               frame_cnt
);

  // --------------------------------------------------------------------------
  // Timing constants. Range limits are held at 12 bits so that a sync or
  // blanking window ending exactly at 2048 still compares correctly against
  // an 11-bit counter.
  // --------------------------------------------------------------------------
  localparam int unsigned c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] c_h_last     = 11'(c_h_total - 1);
  localparam logic [10:0] c_v_last     = 11'(c_v_total - 1);
  localparam logic [11:0] c_h_blank    = 12'(H_ACTIVE);
  localparam logic [11:0] c_v_blank    = 12'(V_ACTIVE);
  localparam logic [11:0] c_hs_start   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] c_hs_end     = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] c_vs_start   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] c_vs_end     = 12'(V_ACTIVE + V_FP + V_SYNC);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q,  hsync_d;
  logic        vsync_q,  vsync_d;
  logic        hblnk_q,  hblnk_d;
  logic        vblnk_q,  vblnk_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_cnt_q,   frame_cnt_d;
  logic [11:0] w_rgb;

  logic        w_h_wrap;
  logic        w_v_wrap;

  // --------------------------------------------------------------------------
  // Next pixel position and frame bookkeeping. With en low every next value
  // equals the current one, so the whole bus holds and the pulse drops.
  // --------------------------------------------------------------------------
  always_comb begin
    w_h_wrap      = (hcount_q == c_h_last);
    w_v_wrap      = (vcount_q == c_v_last);
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    if (en) begin
      if (w_h_wrap) begin
        hcount_d = '0;
        if (w_v_wrap) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + 16'd1;
        end else begin
          vcount_d = vcount_q + 11'd1;
        end
      end else begin
        hcount_d = hcount_q + 11'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sync and blanking are decoded from the next position so that, once
  // registered, they line up with the counters they describe.
  // --------------------------------------------------------------------------
  always_comb begin
    hblnk_d = ({1'b0, hcount_d} >= c_h_blank);
    vblnk_d = ({1'b0, vcount_d} >= c_v_blank);

    hsync_d = (({1'b0, hcount_d} >= c_hs_start) && ({1'b0, hcount_d} < c_hs_end))
              ? HS_POL : ~HS_POL;
    vsync_d = (({1'b0, vcount_d} >= c_vs_start) && ({1'b0, vcount_d} < c_vs_end))
              ? VS_POL : ~VS_POL;
  end

  // --------------------------------------------------------------------------
  // Counter, sync, blanking and frame registers
  // --------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

`ifdef VGA_TIMING_PATTERN_EN
  // --------------------------------------------------------------------------
  // Colour bar test pattern: eight bars of H_ACTIVE/8 pixels each. The bar
  // index comes from a threshold ladder rather than a divider. Any pixels
  // left over when H_ACTIVE is not a multiple of 8 fall into the last bar.
  // --------------------------------------------------------------------------
  localparam int unsigned c_bar_w = H_ACTIVE / 8;

  logic [2:0]  w_bar_idx;
  logic [11:0] rgb_d;
  logic [11:0] rgb_q;

  always_comb begin
    w_bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if ({1'b0, hcount_d} >= 12'(i * c_bar_w)) begin
        w_bar_idx = 3'(i);
      end
    end

    case (w_bar_idx)
      3'd0:    rgb_d = 12'hFFF;  // white
      3'd1:    rgb_d = 12'hFF0;  // yellow
      3'd2:    rgb_d = 12'h0FF;  // cyan
      3'd3:    rgb_d = 12'h0F0;  // green
      3'd4:    rgb_d = 12'hF0F;  // magenta
      3'd5:    rgb_d = 12'hF00;  // red
      3'd6:    rgb_d = 12'h00F;  // blue
      default: rgb_d = 12'h000;  // black
    endcase

    if (hblnk_d || vblnk_d) begin
      rgb_d = 12'h000;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= 12'h000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign w_rgb = rgb_q;
`else
  // Colour belongs to the downstream drawing stages.
  assign w_rgb = 12'h000;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign vga_out     = {hcount_q, vcount_q, hsync_q, vsync_q, hblnk_q, vblnk_q, w_rgb};
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed self-checking bench for vga_timing_gen. Uses a small
//               timing (24 x 12 frame, hsync active high, vsync active low)
//               so that whole frames fit in a short run.
//               Bus expected values are hand-derived from the small timing:
//                 hblnk for h >= 16, hsync high for h in 18..21,
//                 vblnk for v >= 8,  vsync low  for v in 9..10.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

module tb_vga_timing_gen;

  localparam int BW = `VGA_BUS_SIZE;

  logic          pclk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [BW-1:0] vga_out;
  logic          frame_start;
  logic [15:0]   frame_cnt;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [BW-1:0] c_reset_bus = {11'd0, 11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000};

  always #5 pclk = ~pclk;

  vga_timing_gen #(
    .H_ACTIVE (16),
    .H_FP     (2),
    .H_SYNC   (4),
    .H_BP     (2),
    .V_ACTIVE (8),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (1),
    .HS_POL   (1'b1),
    .VS_POL   (1'b0)
  ) dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .en          (en),
    .vga_out     (vga_out),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  // Expected bus for pixel (h, v) of the 24 x 12 test timing.
  function automatic logic [BW-1:0] exp_bus(input int h, input int v);
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    hs  = (h >= 18) && (h < 22);
    vs  = !((v >= 9) && (v < 11));
    hb  = (h >= 16);
    vb  = (v >= 8);
    rgb = 12'h000;
`ifdef VGA_TIMING_PATTERN_EN
    if (!hb && !vb) begin
      case (h / 2)
        0: rgb = 12'hFFF;
        1: rgb = 12'hFF0;
        2: rgb = 12'h0FF;
        3: rgb = 12'h0F0;
        4: rgb = 12'hF0F;
        5: rgb = 12'hF00;
        6: rgb = 12'h00F;
        default: rgb = 12'h000;
      endcase
    end
`endif
    return {11'(h), 11'(v), hs, vs, hb, vb, rgb};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance n rising edges, then sample 1 time unit later.
  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;

    // Reset state, including with en raised while reset is held.
    step(3);
    chk("reset_bus", 64'(vga_out), 64'(c_reset_bus));
    chk("reset_fs", 64'(frame_start), 64'd0);
    chk("reset_cnt", 64'(frame_cnt), 64'd0);
    en = 1'b1;
    step(2);
    chk("reset_hold_bus", 64'(vga_out), 64'(c_reset_bus));

    // Release; the next edge is the first enabled one. Sweep a whole frame.
    rst_n = 1'b1;
    for (int e = 1; e < 288; e++) begin
      step(1);
      chk($sformatf("sweep_bus e=%0d", e), 64'(vga_out), 64'(exp_bus(e % 24, e / 24)));
      chk($sformatf("sweep_fs e=%0d", e), 64'(frame_start), 64'd0);
    end
    chk("sweep_cnt", 64'(frame_cnt), 64'd0);

    // Frame wrap: (23,11) -> (0,0) with a single-cycle pulse.
    step(1);
    chk("wrap1_bus", 64'(vga_out), 64'(exp_bus(0, 0)));
    chk("wrap1_fs", 64'(frame_start), 64'd1);
    chk("wrap1_cnt", 64'(frame_cnt), 64'd1);
    step(1);
    chk("after_wrap_bus", 64'(vga_out), 64'(exp_bus(1, 0)));
    chk("after_wrap_fs", 64'(frame_start), 64'd0);
    chk("after_wrap_cnt", 64'(frame_cnt), 64'd1);

    // Freeze mid-frame at (12,6) for 10 cycles, then resume with no skip.
    step(155);
    chk("pre_freeze_bus", 64'(vga_out), 64'(exp_bus(12, 6)));
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk($sformatf("freeze_bus k=%0d", k), 64'(vga_out), 64'(exp_bus(12, 6)));
      chk($sformatf("freeze_fs k=%0d", k), 64'(frame_start), 64'd0);
    end
    chk("freeze_cnt", 64'(frame_cnt), 64'd1);
    en = 1'b1;
    step(1);
    chk("resume_bus", 64'(vga_out), 64'(exp_bus(13, 6)));

    // Freeze right at the last pixel: no pulse and no count until enabled.
    step(130);
    chk("last_px_bus", 64'(vga_out), 64'(exp_bus(23, 11)));
    en = 1'b0;
    step(3);
    chk("last_px_hold_bus", 64'(vga_out), 64'(exp_bus(23, 11)));
    chk("last_px_hold_fs", 64'(frame_start), 64'd0);
    chk("last_px_hold_cnt", 64'(frame_cnt), 64'd1);
    en = 1'b1;
    step(1);
    chk("wrap2_bus", 64'(vga_out), 64'(exp_bus(0, 0)));
    chk("wrap2_fs", 64'(frame_start), 64'd1);
    chk("wrap2_cnt", 64'(frame_cnt), 64'd2);

    // Asynchronous reset mid-frame at (17,9), checked before the next edge.
    step(233);
    chk("pre_rst_bus", 64'(vga_out), 64'(exp_bus(17, 9)));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_bus", 64'(vga_out), 64'(c_reset_bus));
    chk("async_rst_fs", 64'(frame_start), 64'd0);
    chk("async_rst_cnt", 64'(frame_cnt), 64'd0);

    // After release, the next pulse needs a full 288 enabled edges.
    @(posedge pclk);
    #1;
    rst_n = 1'b1;
    for (int e = 1; e < 288; e++) begin
      step(1);
      chk($sformatf("post_rst_fs e=%0d", e), 64'(frame_start), 64'd0);
    end
    chk("post_rst_last_bus", 64'(vga_out), 64'(exp_bus(23, 11)));
    step(1);
    chk("post_rst_wrap_bus", 64'(vga_out), 64'(exp_bus(0, 0)));
    chk("post_rst_wrap_fs", 64'(frame_start), 64'd1);
    chk("post_rst_wrap_cnt", 64'(frame_cnt), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
